if_id_pipe_reg: RTL and testbench
=================================

Name: if_id_pipe_reg

Overview:
- IF/ID pipeline register with a 2-entry skid buffer.
- Sits directly downstream of the PC register and pc_inc_adder in the IF stage.
- Captures the fetch bundle (PC_out, inc_pc, fetched instruction) and presents it to the ID stage.
- Uses a valid/ready handshake so ID back-pressure stalls fetch without dropping beats; a synchronous flush squashes in-flight fetches on branch redirect.

Parameters:
- XLEN, 32, datapath width of PC and instruction.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) driven on id_instr when empty, flushed or reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- PC_out  input  XLEN  PC of the fetched instruction.
- inc_pc  input  XLEN  PC_out+4 from pc_inc_adder.
- instr  input  XLEN  instruction word from instruction memory.
- if_valid  input  1  fetch bundle valid this cycle.
- if_ready  output  1  register can accept a bundle this cycle.
- flush  input  1  squash all held bundles (branch taken / redirect).
- id_valid  output  1  bundle presented to ID is valid.
- id_ready  input  1  ID consumes the bundle this cycle.
- id_pc  output  XLEN  held PC_out.
- id_inc_pc  output  XLEN  held inc_pc.
- id_instr  output  XLEN  held instruction; NOP_INSTR when not valid.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=EMPTY, id_valid=0, id_pc=0, id_inc_pc=0, id_instr=NOP_INSTR.
  - Skid entry cleared; if_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all held bundles.
- Accept event: if_valid && if_ready at posedge.
- Consume event: id_valid && id_ready at posedge.
- Storage:
  - Main entry drives the id_* outputs.
  - Skid entry is internal.
  - if_ready = (state != SKID); combinational from registered state only, with no path from id_ready to if_ready.
- State machine (states EMPTY, FULL, SKID):
  - EMPTY: accept -> FULL, main <= input bundle.
  - FULL: accept && consume -> FULL, main <= input.
  - FULL: accept && !consume -> SKID, skid <= input, main unchanged.
  - FULL: !accept && consume -> EMPTY.
  - FULL: neither event -> hold.
  - SKID: consume -> FULL, main <= skid. No accept is possible because if_ready=0.
  - SKID: !consume -> hold.
- Latency and ordering:
  - One cycle from accept to id_valid=1 when the register was empty or consuming.
  - Bundles leave in acceptance order; none are duplicated or dropped.
- Stability: while id_valid && !id_ready, id_pc, id_inc_pc and id_instr hold constant.
- Flush:
  - Priority is rst_n > flush > handshake.
  - flush=1 at posedge -> state=EMPTY, id_valid=0, id_instr=NOP_INSTR, skid cleared.
  - A bundle offered in the same cycle is dropped even if if_valid && if_ready.
  - id_pc and id_inc_pc may retain stale values but must not be used while id_valid=0.
  - flush while EMPTY is a no-op.
- Width rules:
  - All data is passed through unmodified; no arithmetic in the block.
  - Wrap-around values, e.g. PC_out=32'hFFFFFFFC with inc_pc=32'h00000000, pass through bit-exact.
- When state=EMPTY: id_instr=NOP_INSTR and id_valid=0, regardless of stale data.

Decomposition:
- Shared package if_id_pkg:
  - NOP_INSTR constant.
  - State enum {EMPTY, FULL, SKID}.
  - Packed struct if_id_bundle_t {pc, inc_pc, instr}, each XLEN.
  - The struct is reused by the ID stage.
- The two entries are plain registers of if_id_bundle_t; no sub-module is needed, and the FSM and entries stay flat in if_id_pipe_reg.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with if_valid=1 -> id_valid=0, id_instr=32'h00000013, if_ready=1 after release.
- Streaming: id_ready=1; offer PC_out=16, inc_pc=20, instr=32'h00500093, then PC_out=20, inc_pc=24, instr=32'h00A00113 on consecutive cycles -> id_pc shows 16 then 20, each one cycle after its accept, id_valid continuous, if_ready stays 1.
- Back-pressure: id_ready=0, offer bundles at PC 16 and 20 -> state=SKID and if_ready=0 after the 2nd accept; id_pc=16 held. Raise id_ready -> 16 is consumed, then 20 is consumed, and no bundle is lost.
- Flush in SKID: with PC 16 and 20 held, assert flush together with if_valid at PC 24 -> next cycle id_valid=0, id_instr=32'h00000013, if_ready=1, and PC 24 never appears.
- Wrap-around: PC_out=32'hFFFFFFFC, inc_pc=32'h00000000 -> id_pc and id_inc_pc match bit-exact.
- Reset mid-operation: in SKID, pull rst_n=0 for 1 cycle -> EMPTY, id_valid=0, and no stale bundle is presented afterwards.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared IF/ID types: bubble encoding, occupancy states and the fetch bundle.
package if_id_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } if_id_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inc_pc;
        logic [XLEN-1:0] instr;
    } if_id_bundle_t;

    function automatic if_id_bundle_t make_bundle(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] inc_pc,
                                                  input logic [XLEN-1:0] instr);
        if_id_bundle_t b;
        b.pc     = pc;
        b.inc_pc = inc_pc;
        b.instr  = instr;
        return b;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: main entry feeds ID, skid entry absorbs one extra
// beat so if_ready depends only on registered state.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int              XLEN      = if_id_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = if_id_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC_out,
    input  logic [XLEN-1:0] inc_pc,
    input  logic [XLEN-1:0] instr,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inc_pc,
    output logic [XLEN-1:0] id_instr
);

    if_id_state_t  state;
    if_id_bundle_t main_entry;
    if_id_bundle_t skid_entry;
    if_id_bundle_t in_bundle;
    logic          accept;
    logic          consume;

    assign in_bundle = make_bundle(PC_out, inc_pc, instr);
    assign if_ready  = (state != SKID);
    assign id_valid  = (state != EMPTY);
    assign accept    = if_valid && if_ready;
    assign consume   = id_valid && id_ready;

    assign id_pc     = main_entry.pc;
    assign id_inc_pc = main_entry.inc_pc;
    // Stale main data after a flush is masked to a bubble on the instruction.
    assign id_instr  = (state == EMPTY) ? NOP_INSTR : main_entry.instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            skid_entry <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_entry <= in_bundle;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        main_entry <= in_bundle;
                    end else if (accept) begin
                        skid_entry <= in_bundle;
                        state      <= SKID;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (consume) begin
                        main_entry <= skid_entry;
                        state      <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench: a 2-deep FIFO model predicts every bundle ID must see.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inc;
        logic [31:0] ins;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_out;
    logic [31:0] inc_pc;
    logic [31:0] instr;
    logic        if_valid;
    logic        if_ready;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inc_pc;
    logic [31:0] id_instr;

    exp_t model[$];
    int   checks;
    int   errors;
    bit   started;

    if_id_pipe_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PC_out   (PC_out),
        .inc_pc   (inc_pc),
        .instr    (instr),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inc_pc(id_inc_pc),
        .id_instr (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; the model applies accept/flush/reset after
    // the monitor has taken its pop for the same edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] inc, input logic [31:0] ins,
                                 input logic rdy, input logic fl, input logic rn);
        bit acc;
        @(negedge clk);
        if_valid = v;
        PC_out   = pc;
        inc_pc   = inc;
        instr    = ins;
        id_ready = rdy;
        flush    = fl;
        rst_n    = rn;
        acc      = v && (model.size() < 2);
        #2;
        if (!rn || fl) model.delete();
        else if (acc) model.push_back('{pc, inc, ins});
        started = 1'b1;
    endtask

    always @(negedge clk) begin
        #1;
        if (started) begin
            checkOutput("if_ready", {31'b0, if_ready}, {31'b0, model.size() < 2});
            checkOutput("id_valid", {31'b0, id_valid}, {31'b0, model.size() != 0});
            if (model.size() == 0) begin
                checkOutput("id_instr_bubble", id_instr, NOP);
            end else begin
                checkOutput("id_pc", id_pc, model[0].pc);
                checkOutput("id_inc_pc", id_inc_pc, model[0].inc);
                checkOutput("id_instr", id_instr, model[0].ins);
                if (id_ready) void'(model.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] pc;
        checks   = 0;
        errors   = 0;
        started  = 1'b0;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        PC_out   = '0;
        inc_pc   = '0;
        instr    = '0;

        // Reset held two cycles while fetch offers a bundle.
        applyStimulus(1, 32'd8, 32'd12, 32'h00100093, 1, 0, 0);
        applyStimulus(1, 32'd8, 32'd12, 32'h00100093, 1, 0, 0);
        checkOutput("reset_id_pc", id_pc, 32'd0);
        checkOutput("reset_id_inc_pc", id_inc_pc, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Streaming with ID always ready.
        applyStimulus(1, 32'd16, 32'd20, 32'h00500093, 1, 0, 1);
        applyStimulus(1, 32'd20, 32'd24, 32'h00A00113, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Back-pressure into the skid entry, then drain.
        applyStimulus(1, 32'd16, 32'd20, 32'h00500093, 0, 0, 1);
        applyStimulus(1, 32'd20, 32'd24, 32'h00A00113, 0, 0, 1);
        applyStimulus(1, 32'd24, 32'd28, 32'h00F00193, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Flush while two bundles are held, with a competing offer.
        applyStimulus(1, 32'd16, 32'd20, 32'h00500093, 0, 0, 1);
        applyStimulus(1, 32'd20, 32'd24, 32'h00A00113, 0, 0, 1);
        applyStimulus(1, 32'd24, 32'd28, 32'h00F00193, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);

        // Wrap-around values pass bit-exact.
        applyStimulus(1, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Reset while in SKID.
        applyStimulus(1, 32'd40, 32'd44, 32'h00200093, 0, 0, 1);
        applyStimulus(1, 32'd44, 32'd48, 32'h00300093, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Randomized traffic with occasional flush and reset.
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 15) == 0) ? ($urandom() & 32'hFFFFFFFC) : pc;
            applyStimulus($urandom_range(0, 3) != 0, p, p + 32'd4, $urandom(),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                          $urandom_range(0, 127) != 0);
            if (if_valid && (p == pc)) pc = pc + 32'd4;
        end

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
